mul_seq_ctrl: RTL and testbench

Sequencing controller for the EX-stage multiply path. It accepts one signed 16-bit × 9-bit MUL operation per request and runs a radix-2 shift-add datapath over several cycles. While the operation is in flight it holds the pipeline stall. It delivers a signed 25-bit product with a one-cycle done pulse, so the EX_WB register captures `C` on that cycle.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/mul_shift_add_dp.sv | 61 ++++++
 rtl/mul_seq_ctrl.sv | 109 ++++++++++
 tb/tb_mul_seq_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU package: multiply-path operand/product widths and the
// multiply sequencer state encoding.
package cpu_pkg;

  localparam int MD_WD   = 16;
  localparam int MR_WD   = 9;
  localparam int MDMR_WD = MD_WD + MR_WD;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } mul_state_t;

endpackage

// File: rtl/mul_shift_add_dp.sv
// Radix-2 shift-add multiply datapath: operand magnitudes, accumulator,
// and the final sign correction into the held product register.
module mul_shift_add_dp
  import cpu_pkg::*;
#(
  parameter int MD_WD   = cpu_pkg::MD_WD,
  parameter int MR_WD   = cpu_pkg::MR_WD,
  parameter int MDMR_WD = MD_WD + MR_WD
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_step,
  input  logic               i_sign,
  input  logic [MD_WD-1:0]   i_md,
  input  logic [MR_WD-1:0]   i_mr,
  output logic               o_mr_zero,
  output logic [MDMR_WD-1:0] o_product
);

  logic [MD_WD-1:0]   w_md_mag;
  logic [MR_WD-1:0]   w_mr_mag;
  logic [MDMR_WD-1:0] r_md;
  logic [MR_WD-1:0]   r_mr;
  logic [MDMR_WD-1:0] r_acc;
  logic               r_neg;
  logic [MDMR_WD-1:0] r_product;

  // Two's-complement negation of the most negative value yields 2^(W-1),
  // which reads back correctly as an unsigned magnitude.
  assign w_md_mag = i_md[MD_WD-1] ? MD_WD'(-i_md) : i_md;
  assign w_mr_mag = i_mr[MR_WD-1] ? MR_WD'(-i_mr) : i_mr;

  // Multiplier is zero once the current step's shift has happened.
  assign o_mr_zero = (r_mr[MR_WD-1:1] == '0);
  assign o_product = r_product;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_md      <= '0;
      r_mr      <= '0;
      r_acc     <= '0;
      r_neg     <= 1'b0;
      r_product <= '0;
    end else if (i_load) begin
      r_md  <= MDMR_WD'(w_md_mag);
      r_mr  <= w_mr_mag;
      r_acc <= '0;
      r_neg <= i_md[MD_WD-1] ^ i_mr[MR_WD-1];
    end else if (i_step) begin
      if (r_mr[0]) begin
        r_acc <= r_acc + r_md;
      end
      r_md <= r_md << 1;
      r_mr <= r_mr >> 1;
    end else if (i_sign) begin
      r_product <= r_neg ? -r_acc : r_acc;
    end
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// EX-stage multiply sequencer: FSM, step counter and pipeline stall.
// Optional early termination when the multiplier runs out: CPU_MUL_EARLY_TERM_EN.
module mul_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int MD_WD   = cpu_pkg::MD_WD,
  parameter int MR_WD   = cpu_pkg::MR_WD,
  parameter int MDMR_WD = MD_WD + MR_WD
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [MD_WD-1:0]   md,
  input  logic [MR_WD-1:0]   mr,
  input  logic               flush,
  output logic               stall,
  output logic               busy,
  output logic               done,
  output logic [MDMR_WD-1:0] product
);

  localparam int CNT_WD = $clog2(MR_WD + 1);
  localparam logic [CNT_WD-1:0] CNT_LAST = CNT_WD'(MR_WD - 1);
`ifdef CPU_MUL_EARLY_TERM_EN
  localparam bit EARLY_TERM = 1'b1;
`else
  localparam bit EARLY_TERM = 1'b0;
`endif

  mul_state_t        r_state;
  mul_state_t        w_state_next;
  logic [CNT_WD-1:0] r_cnt;
  logic [CNT_WD-1:0] w_cnt_next;
  logic              w_accept;
  logic              w_load;
  logic              w_step;
  logic              w_sign;
  logic              w_term;
  logic              w_mr_zero;

  assign w_accept = ((r_state == IDLE) || (r_state == DONE)) && start && !flush;
  assign w_term   = (r_cnt == CNT_LAST) || (EARLY_TERM && w_mr_zero);

  assign busy  = (r_state == CALC) || (r_state == SIGN);
  assign stall = w_accept || busy;
  assign done  = (r_state == DONE) && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_sign       = 1'b0;
    if (flush) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            w_state_next = CALC;
            w_cnt_next   = '0;
            w_load       = 1'b1;
          end else begin
            w_state_next = IDLE;
          end
        end
        CALC: begin
          w_step     = 1'b1;
          w_cnt_next = r_cnt + CNT_WD'(1);
          if (w_term) begin
            w_state_next = SIGN;
          end
        end
        SIGN: begin
          w_sign       = 1'b1;
          w_state_next = DONE;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  mul_shift_add_dp #(
    .MD_WD  (MD_WD),
    .MR_WD  (MR_WD),
    .MDMR_WD(MDMR_WD)
  ) u_dp (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_sign   (w_sign),
    .i_md     (md),
    .i_mr     (mr),
    .o_mr_zero(w_mr_zero),
    .o_product(product)
  );

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: cycle-level reference model plus
// hand-computed literal expectations for products and latencies.
module tb_mul_seq_ctrl;

  localparam int MR_STEPS = 9;
`ifdef CPU_MUL_EARLY_TERM_EN
  localparam int LAT_3X5  = 5;
  localparam int LAT_MR0  = 3;
  localparam int LAT_MR1  = 3;
  localparam int LAT_B2B1 = 5;
  localparam int LAT_B2B2 = 4;
`else
  localparam int LAT_3X5  = 11;
  localparam int LAT_MR0  = 11;
  localparam int LAT_MR1  = 11;
  localparam int LAT_B2B1 = 11;
  localparam int LAT_B2B2 = 11;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic signed [15:0] md;
  logic signed [8:0]  mr;
  logic               flush;
  logic               stall;
  logic               busy;
  logic               done;
  logic [24:0]        product;

  int n_checks = 0;
  int n_fail   = 0;

  mul_seq_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .md     (md),
    .mr     (mr),
    .flush  (flush),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  always #5 clk = ~clk;

  // Number of CALC cycles an operation needs.
  function automatic int mr_steps(input logic signed [8:0] b);
`ifdef CPU_MUL_EARLY_TERM_EN
    int a;
    int n;
    a = (b < 0) ? -int'(b) : int'(b);
    n = 0;
    while (a != 0) begin
      n++;
      a = a >> 1;
    end
    return (n == 0) ? 1 : n;
`else
    return MR_STEPS;
`endif
  endfunction

  // Reference model: countdown of busy cycles left, exact product from
  // plain signed multiplication, done flag for the cycle after completion.
  int          m_left    = 0;
  bit          m_done    = 1'b0;
  logic [24:0] m_result  = '0;
  logic [24:0] m_product = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left    <= 0;
      m_done    <= 1'b0;
      m_result  <= '0;
      m_product <= '0;
    end else if (flush) begin
      m_left <= 0;
      m_done <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      m_done <= (m_left == 1);
      if (m_left == 1) m_product <= m_result;
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_left   <= mr_steps(mr) + 1;
        m_result <= 25'(int'(md) * int'(mr));
      end
    end
  end

  always @(negedge clk) begin
    logic e_busy;
    logic e_done;
    logic e_stall;
    e_busy  = (m_left > 0);
    e_done  = m_done && !flush;
    e_stall = e_busy || (start && !flush);
    n_checks++;
    if ({stall, busy, done, product} !== {e_stall, e_busy, e_done, m_product}) begin
      n_fail++;
      $display("FAIL cycle_model t=%0t stall/busy/done/product got=%b/%b/%b/%h want=%b/%b/%b/%h",
               $time, stall, busy, done, product, e_stall, e_busy, e_done, m_product);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h want=0x%0h", name, act, exp);
    end else begin
      $display("check %s value=0x%0h ok", name, act);
    end
  endtask

  task automatic run_op(input logic signed [15:0] a, input logic signed [8:0] b,
                        output int lat, output int stalls, output logic [24:0] prod);
    lat    = -1;
    stalls = 0;
    prod   = '0;
    @(posedge clk); #1;
    start = 1'b1; md = a; mr = b;
    @(negedge clk);
    if (stall) stalls++;
    @(posedge clk); #1;
    start = 1'b0; md = 16'($urandom); mr = 9'($urandom);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (stall) stalls++;
      if (done) begin
        lat  = k;
        prod = product;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL op_timeout md=%0d mr=%0d got=no_done want=done", a, b);
    end
    $display("txn md=%0d mr=%0d product=%0d latency=%0d stall_cycles=%0d",
             a, b, $signed(prod), lat, stalls);
  endtask

  initial begin
    int          lat;
    int          st;
    int          n_done;
    logic [24:0] p;
    logic        s;

    start = 1'b0; flush = 1'b0; md = '0; mr = '0; rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_product", 32'(product), 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;

    run_op(16'sd3, 9'sd5, lat, st, p);
    chk("mul_3x5_product", 32'(p), 32'd15);
    chk("mul_3x5_latency", 32'(lat), 32'(LAT_3X5));
    chk("mul_3x5_stall_cycles", 32'(st), 32'(LAT_3X5));

    run_op(-16'sd7, 9'sd3, lat, st, p);
    chk("mul_m7x3_product", 32'(p), 32'h1FFFFEB);

    run_op(-16'sd32768, -9'sd256, lat, st, p);
    chk("mul_min_x_min_product", 32'(p), 32'h0800000);
    chk("mul_min_x_min_latency", 32'(lat), 32'd11);

    run_op(16'sd0, 9'sd77, lat, st, p);
    chk("mul_md0_product", 32'(p), 32'd0);

    run_op(16'sd1234, 9'sd0, lat, st, p);
    chk("mul_mr0_product", 32'(p), 32'd0);
    chk("mul_mr0_latency", 32'(lat), 32'(LAT_MR0));

    run_op(16'sd100, 9'sd1, lat, st, p);
    chk("mul_100x1_product", 32'(p), 32'd100);
    chk("mul_100x1_latency", 32'(lat), 32'(LAT_MR1));

    run_op(-16'sd1, -9'sd1, lat, st, p);
    chk("mul_m1xm1_product", 32'(p), 32'd1);

    // Flush on cycle 4 of an operation.
    @(posedge clk); #1;
    start = 1'b1; md = 16'sd50; mr = -9'sd256;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_cycle_busy", 32'(busy), 32'd1);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_next_busy", 32'(busy), 32'd0);
    chk("flush_product_kept", 32'(product), 32'd1);
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("flush_no_done", 32'(n_done), 32'd0);
    $display("txn flush md=50 mr=-256 dones_after=%0d", n_done);

    // start and flush together: flush wins.
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; md = 16'sd3; mr = 9'sd3;
    @(negedge clk);
    chk("start_flush_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("start_flush_busy", 32'(busy), 32'd0);
    $display("txn start_with_flush not accepted");

    // start re-asserted during CALC is ignored.
    @(posedge clk); #1;
    start = 1'b1; md = 16'sd5; mr = -9'sd256;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; md = 16'sd9; mr = 9'sd3;
    repeat (4) @(posedge clk);
    #1 start = 1'b0;
    n_done = 0;
    p = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        p = product;
      end
    end
    chk("ignored_start_done_count", 32'(n_done), 32'd1);
    chk("ignored_start_product", 32'(p), 32'h1FFFB00);
    $display("txn ignored_start md=5 mr=-256 product=%0d dones=%0d", $signed(p), n_done);

    // Second request held under stall, accepted in the DONE cycle.
    @(posedge clk); #1;
    start = 1'b1; md = 16'sd6; mr = -9'sd4;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; md = 16'sd2; mr = 9'sd2;
    lat = -1; p = '0; s = 1'b0;
    for (int k = 2; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        p   = product;
        s   = stall;
        break;
      end
      @(posedge clk); #1;
    end
    chk("b2b_first_latency", 32'(lat), 32'(LAT_B2B1));
    chk("b2b_first_product", 32'(p), 32'h1FFFFE8);
    chk("b2b_done_cycle_stall", 32'(s), 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; p = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        p   = product;
        break;
      end
      @(posedge clk); #1;
    end
    chk("b2b_second_latency", 32'(lat), 32'(LAT_B2B2));
    chk("b2b_second_product", 32'(p), 32'd4);
    $display("txn back_to_back second md=2 mr=2 product=%0d latency=%0d", $signed(p), lat);

    // Asynchronous reset in the middle of CALC.
    @(posedge clk); #1;
    start = 1'b1; md = 16'sd300; mr = 9'sd200;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("async_rst_stall", 32'(stall), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    chk("async_rst_product", 32'(product), 32'd0);
    $display("txn async_reset mid-CALC");
    @(posedge clk); #3 rst_n = 1'b1;

    run_op(16'sd3, 9'sd5, lat, st, p);
    chk("post_reset_product", 32'(p), 32'd15);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
